// File: rtl/f1_delay_ctrl_if.sv
// ============================================================================
//  Module   : f1_delay_ctrl_if
//  Purpose  : Signal bundle between the start-lights FSM and the F1 random
//             delay controller.
//  Signals  : cmd_seq     - lights-sequence request (FSM -> controller)
//             cmd_delay   - lights-out / delay request (FSM -> controller)
//             btn         - synchronised driver button, active-high
//             en          - one-cycle tick stepping the lights FSM
//             time_out    - one-cycle pulse at the end of the random delay
//             busy        - random delay in progress
//             delay_val   - delay length K (ticks) of the last captured delay
//             jump_start  - one-cycle pulse on an early button press
//  Modports : master (requester / testbench side), slave (controller side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface f1_delay_ctrl_if;
    logic       cmd_seq;
    logic       cmd_delay;
    logic       btn;
    logic       en;
    logic       time_out;
    logic       busy;
    logic [6:0] delay_val;
    logic       jump_start;

    modport master (
        output cmd_seq, cmd_delay, btn,
        input  en, time_out, busy, delay_val, jump_start
    );

    modport slave (
        input  cmd_seq, cmd_delay, btn,
        output en, time_out, busy, delay_val, jump_start
    );
endinterface

`default_nettype wire

// File: rtl/f1_delay_ctrl.sv
// ============================================================================
//  Module   : f1_delay_ctrl
//  Purpose  : Tick generator and pseudo-random lights-out delay for an F1
//             start-lights controller. A free-running 7-bit LFSR supplies the
//             delay length K (1..127 ticks); a prescaler divides clk by
//             TICK_DIV to form the tick.
//  Params   : TICK_DIV - clock cycles per tick (2..65535)
//             SEED     - LFSR reset value, must be nonzero
//  Ports    : clk      - clock, rising edge
//             rst      - asynchronous reset, active-low
//             bus      - f1_delay_ctrl_if.slave (cmd_seq, cmd_delay, btn in;
//                        en, time_out, busy, delay_val, jump_start out)
//  Options  : F1_JUMP_START_EN - when defined, a button press during the
//             delay pulses jump_start and cancels the delay. When undefined
//             the button is ignored and jump_start stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f1_delay_ctrl #(
    parameter int unsigned TICK_DIV = 16,
    parameter logic [6:0]  SEED     = 7'h5A
) (
    input  wire logic      clk,
    input  wire logic      rst,
    f1_delay_ctrl_if.slave bus
);

    localparam logic [15:0] c_presc_max = 16'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t      r_state;
    logic [6:0]  r_lfsr;
    logic [15:0] r_presc;
    logic [6:0]  r_cnt;
    logic [6:0]  r_delay_val;
    logic        r_cmd_delay_q;
    logic        r_en;
    logic        r_time_out;
    logic        r_jump_start;

    logic        w_presc_run;
    logic        w_tick;
    logic        w_capture;
    logic        w_jump;

    // Prescaler only runs while the lights sequence is stepping or a delay
    // is being timed; otherwise it parks at 0 so the next run starts clean.
    assign w_presc_run = bus.cmd_seq || (r_state == S_COUNT);
    assign w_tick      = w_presc_run && (r_presc == c_presc_max);

    // cmd_delay_q resets to 1, so a request already high out of reset is
    // not mistaken for a rising edge.
    assign w_capture   = (r_state == S_IDLE) && !bus.cmd_seq &&
                         bus.cmd_delay && !r_cmd_delay_q;

`ifdef F1_JUMP_START_EN
    assign w_jump = bus.btn;
`else
    logic w_unused_btn;
    assign w_unused_btn = bus.btn;
    assign w_jump       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_lfsr        <= SEED;
            r_presc       <= '0;
            r_cnt         <= '0;
            r_delay_val   <= '0;
            r_cmd_delay_q <= 1'b1;
            r_en          <= 1'b0;
            r_time_out    <= 1'b0;
            r_jump_start  <= 1'b0;
        end else begin
            // x^7 + x^6 + 1: maximal length, never leaves the nonzero cycle
            r_lfsr        <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_cmd_delay_q <= bus.cmd_delay;
            r_en          <= w_tick && bus.cmd_seq;
            r_time_out    <= 1'b0;
            r_jump_start  <= 1'b0;

            if (!w_presc_run || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_state     <= S_COUNT;
                        r_cnt       <= r_lfsr;
                        r_delay_val <= r_lfsr;
                        r_presc     <= '0;
                    end
                end

                S_COUNT: begin
                    // Priority: sequence abort, then jump start, then tick.
                    if (bus.cmd_seq) begin
                        r_state <= S_IDLE;
                    end else if (w_jump) begin
                        r_jump_start <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (w_tick) begin
                        if (r_cnt > 7'd1) begin
                            r_cnt <= r_cnt - 7'd1;
                        end else begin
                            r_time_out <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.en         = r_en;
    assign bus.time_out   = r_time_out;
    assign bus.busy       = (r_state == S_COUNT);
    assign bus.delay_val  = r_delay_val;
    assign bus.jump_start = r_jump_start;

endmodule

`default_nettype wire

// File: tb/tb_f1_delay_ctrl.sv
// ============================================================================
//  Module   : tb_f1_delay_ctrl
//  Purpose  : Self-checking bench for f1_delay_ctrl (TICK_DIV=4, SEED=7'h5A).
//             Expected delay values come from a precomputed table of the
//             LFSR sequence indexed by clock edges since reset release.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f1_delay_ctrl;

    localparam int         TD   = 4;
    localparam logic [6:0] SEED = 7'h5A;

    logic clk;
    logic rst;

    f1_delay_ctrl_if bus_if ();

    f1_delay_ctrl #(
        .TICK_DIV (TD),
        .SEED     (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: table of successive LFSR values starting at SEED,
    // and the number of rising edges seen since reset was released.
    logic [6:0] seq [127];
    int         n_edge = 0;

    always @(posedge clk) begin
        if (!rst) n_edge <= 0;
        else      n_edge <= n_edge + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Request a delay now; the next edge captures it.
    task automatic capture(output int k);
        k = int'(seq[n_edge % 127]);
        bus_if.cmd_delay = 1'b1;
        @(negedge clk);
        check("cap_busy", bus_if.busy, 1);
        check("cap_delay_val", bus_if.delay_val, k);
        bus_if.cmd_delay = 1'b0;
    endtask

    // Currently at the negedge following capture-edge + from_t edges.
    task automatic expect_timeout(input int k, input int from_t, input bit jiggle);
        bit bad;
        bad = 1'b0;
        for (int t = from_t + 1; t <= TD * k; t++) begin
            @(negedge clk);
            if (t < TD * k) begin
                if (bus_if.time_out !== 1'b0 || bus_if.busy !== 1'b1 ||
                    bus_if.en !== 1'b0 || bus_if.jump_start !== 1'b0 ||
                    bus_if.delay_val !== 7'(k))
                    bad = 1'b1;
                bus_if.cmd_delay = jiggle ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                bus_if.cmd_delay = 1'b0;
            end
        end
        check("delay_window", bad, 0);
        check("timeout_pulse", bus_if.time_out, 1);
        check("timeout_busy", bus_if.busy, 0);
        @(negedge clk);
        check("timeout_width", bus_if.time_out, 0);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        bit bad;
        bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus_if.time_out !== 1'b0 || bus_if.busy !== 1'b0) bad = 1'b1;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        int nd;
        int seen [128];

        seq[0] = SEED;
        for (int i = 1; i < 127; i++)
            seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};

        rst              = 1'b0;
        bus_if.cmd_seq   = 1'b0;
        bus_if.cmd_delay = 1'b1;
        bus_if.btn       = 1'b0;

        // ---- reset state, then cmd_delay held high out of reset ----
        repeat (3) @(negedge clk);
        check("rst_busy", bus_if.busy, 0);
        check("rst_time_out", bus_if.time_out, 0);
        check("rst_en", bus_if.en, 0);
        check("rst_delay_val", bus_if.delay_val, 0);
        check("rst_jump_start", bus_if.jump_start, 0);
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("hold_busy", bus_if.busy, 0);
            check("hold_time_out", bus_if.time_out, 0);
            check("hold_delay_val", bus_if.delay_val, 0);
        end

        // ---- tick generation ----
        bus_if.cmd_delay = 1'b0;
        bus_if.cmd_seq   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            check("en_tick", bus_if.en, (i % TD == 0) ? 1 : 0);
        end
        bus_if.cmd_seq = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("en_off", bus_if.en, 0);
        end

        // ---- random delays, cmd_delay toggled during the count ----
        for (int tr = 0; tr < 6; tr++) begin
            repeat ($urandom_range(1, 15)) @(negedge clk);
            capture(k);
            expect_timeout(k, 0, 1'b1);
        end

        // ---- abort by cmd_seq (first trial collides with the final tick) ----
        for (int tr = 0; tr < 4; tr++) begin
            repeat ($urandom_range(1, 9)) @(negedge clk);
            capture(k);
            r = (tr == 0) ? TD * k - 1 : int'($urandom_range(0, TD * k - 1));
            repeat (r) @(negedge clk);
            bus_if.cmd_seq = 1'b1;
            @(negedge clk);
            check("abort_busy", bus_if.busy, 0);
            check("abort_time_out", bus_if.time_out, 0);
            bus_if.cmd_seq = 1'b0;
            expect_quiet(TD * 127, "abort_quiet");
        end

        // ---- button during the count (first trial on the final tick) ----
        for (int tr = 0; tr < 4; tr++) begin
            repeat ($urandom_range(1, 9)) @(negedge clk);
            capture(k);
            r = (tr == 0) ? TD * k - 1 : int'($urandom_range(0, TD * k - 1));
            repeat (r) @(negedge clk);
            bus_if.btn = 1'b1;
            @(negedge clk);
            bus_if.btn = 1'b0;
`ifdef F1_JUMP_START_EN
            check("js_pulse", bus_if.jump_start, 1);
            check("js_busy", bus_if.busy, 0);
            check("js_time_out", bus_if.time_out, 0);
            @(negedge clk);
            check("js_width", bus_if.jump_start, 0);
            expect_quiet(TD * 127, "js_quiet");
`else
            check("js_off", bus_if.jump_start, 0);
            expect_timeout(k, r + 1, 1'b0);
`endif
        end

        // ---- reset asserted mid-count ----
        repeat (3) @(negedge clk);
        capture(k);
        repeat ($urandom_range(1, TD * k - 1)) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", bus_if.busy, 0);
        check("midrst_time_out", bus_if.time_out, 0);
        check("midrst_delay_val", bus_if.delay_val, 0);
        @(negedge clk);
        rst = 1'b1;
        expect_quiet(TD * 127, "midrst_quiet");

        // ---- 127 captures at successive LFSR offsets ----
        for (int v = 0; v < 128; v++) seen[v] = 0;
        for (int i = 0; i < 127; i++) begin
            k = int'(seq[n_edge % 127]);
            bus_if.cmd_delay = 1'b1;
            @(negedge clk);
            check("lfsr_k", bus_if.delay_val, k);
            if (!$isunknown(bus_if.delay_val)) seen[bus_if.delay_val]++;
            bus_if.cmd_seq   = 1'b1;
            bus_if.cmd_delay = 1'b0;
            @(negedge clk);
            bus_if.cmd_seq = 1'b0;
            @(negedge clk);
        end
        nd = 0;
        for (int v = 1; v < 128; v++) if (seen[v] == 1) nd++;
        check("lfsr_cover", nd, 127);
        check("lfsr_zero", seen[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/f1_delay_ctrl.md
F1_DELAY_CTRL -- requirements
Module: f1_delay_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16: clock cycles per tick; legal range 2..65535.
REQ-002 SHALL have parameter SEED, default 7'h5A: LFSR reset value; must be nonzero.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_seq, input, 1 bit: lights-sequence request from the start-lights FSM.
REQ-006 SHALL have port cmd_delay, input, 1 bit: lights-out/delay request from the start-lights FSM.
REQ-007 SHALL have port btn, input, 1 bit: driver button, already synchronised, active-high.
REQ-008 SHALL have port en, output, 1 bit: one-cycle tick stepping the lights FSM.
REQ-009 SHALL have port time_out, output, 1 bit: one-cycle pulse at the end of the random delay.
REQ-010 SHALL have port busy, output, 1 bit: high while a random delay is in progress.
REQ-011 SHALL have port delay_val, output, 7 bits: delay length K, in ticks, of the last captured delay.
REQ-012 SHALL have port jump_start, output, 1 bit: one-cycle pulse on an early button press.

Function
REQ-013 SHALL run a free-running 7-bit Fibonacci LFSR (x^7+x^6+1, feedback = bit6 XOR bit5, shift left) that advances every cycle.
REQ-014 The LFSR SHALL never reach zero; its period SHALL be 127.
REQ-015 SHALL keep a prescaler counting 0..TICK_DIV-1 while cmd_seq=1 or state=COUNT, and hold it at 0 otherwise.
REQ-016 The prescaler SHALL raise an internal tick on the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-017 en SHALL be a registered copy of the tick, gated by cmd_seq=1; it SHALL be 0 in all other states.
REQ-018 With cmd_seq held at 1, en SHALL first assert TICK_DIV cycles after cmd_seq is first sampled high.
REQ-019 SHALL register cmd_delay into cmd_delay_q every cycle; a rising edge is cmd_delay=1 AND cmd_delay_q=0.
REQ-020 SHALL implement a two-state FSM, IDLE and COUNT.
REQ-021 IDLE to COUNT: on a rising edge with cmd_seq=0, load cnt and delay_val with the current LFSR value K and clear the prescaler.
REQ-022 COUNT: on each tick, while cnt>1, decrement cnt.
REQ-023 COUNT to IDLE: on the tick with cnt=1, assert time_out (registered) for exactly one cycle.
REQ-024 time_out SHALL assert exactly K*TICK_DIV cycles after the capturing edge.
REQ-025 COUNT to IDLE abort: if cmd_seq=1 is sampled in COUNT, return to IDLE with no time_out; abort SHALL take priority over a same-cycle tick.
REQ-026 A rising edge of cmd_delay in COUNT SHALL be ignored; the delay SHALL NOT restart.
REQ-027 busy SHALL be 1 exactly when state=COUNT.
REQ-028 delay_val SHALL hold its value until the next capture.

Reset
REQ-029 While rst=0, SHALL force the following values: state=IDLE, LFSR=SEED, prescaler=0, cnt=0, delay_val=0, cmd_delay_q=1, en=0, time_out=0, jump_start=0.
REQ-030 cmd_delay_q resets to 1 so that a cmd_delay held high out of reset produces no capture.
REQ-031 Reset asserted mid-COUNT SHALL abort the delay immediately; no time_out SHALL be generated.

Configuration
REQ-032 Macro F1_JUMP_START_EN defined: btn=1 sampled in COUNT SHALL pulse jump_start for one registered cycle and return the FSM to IDLE with no time_out.
REQ-033 btn SHALL take priority over a same-cycle final tick.
REQ-034 Macro F1_JUMP_START_EN undefined: btn SHALL be ignored and jump_start tied 0; all port lists stay identical.

Verification (TICK_DIV=4, SEED=7'h5A)
REQ-035 Reset test: release rst with cmd_delay=1 and hold 200 cycles -> busy=0, time_out=0, delay_val=0 throughout.
REQ-036 Tick test: cmd_seq=1 for 40 cycles -> en pulses at cycles 4, 8, ..., 40, each pulse 1 cycle wide; en=0 after cmd_seq drops.
REQ-037 Delay test: cmd_seq 1 to 0 and cmd_delay 0 to 1 -> delay_val=K matches the reference-model LFSR; one time_out pulse exactly 4*K cycles after capture; busy falls with it.
REQ-038 Abort test: cmd_seq=1 during COUNT -> next cycle busy=0; no time_out within 4*127 cycles.
REQ-039 Jump-start test, macro on: btn=1 for 1 cycle mid-COUNT -> jump_start pulse 1 cycle, busy=0, no time_out; macro off: the same stimulus leaves time_out on schedule and jump_start=0.
REQ-040 LFSR test: 127 consecutive captures, one per cycle offset -> every K in 1..127 appears exactly once; K=0 never appears.
